// File: rtl/psum_accum_requant_if.sv
// psum_accum_requant_if: config, bias, partial-sum input and requantised output bundle.
interface psum_accum_requant_if #(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 19,
  parameter int RW         = 5
);
  logic                          load_layer_info;
  logic [RW-1:0]                 num_rows;
  logic [3:0]                    num_passes;
  logic [4:0]                    shift;
  logic                          relu_en;
  logic                          bias_iv;
  logic [WIDTH*DATA_WIDTH-1:0]   bias_id;
  logic                          data_iv;
  logic [WIDTH*PSUM_WIDTH-1:0]   data_id;
  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH*DATA_WIDTH-1:0]   out_data;
  logic                          busy;
  logic                          err_drop;
  modport master (
    output load_layer_info, num_rows, num_passes, shift, relu_en,
    output bias_iv, bias_id, data_iv, data_id, out_ready,
    input  out_valid, out_data, busy, err_drop
  );
  modport slave (
    input  load_layer_info, num_rows, num_passes, shift, relu_en,
    input  bias_iv, bias_id, data_iv, data_id, out_ready,
    output out_valid, out_data, busy, err_drop
  );
endinterface

// File: rtl/psum_accum_requant.sv
// psum_accum_requant: multi-pass partial-sum accumulation, bias add, ReLU and rounding requantisation.
module psum_accum_requant #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 2*DATA_WIDTH+$clog2(HEIGHT),
  parameter int ACC_WIDTH  = PSUM_WIDTH+4,
  parameter int ROWS_MAX   = 16,
  parameter int RW         = $clog2(ROWS_MAX+1)
) (
  input logic                clk,
  input logic                nrst,
  psum_accum_requant_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  localparam int AW   = ROWS_MAX > 1 ? $clog2(ROWS_MAX) : 1;
  localparam int ACCX = ACC_WIDTH+1;
  localparam logic [ACC_WIDTH:0]        ONE  = ACCX'(1);
  localparam logic signed [ACC_WIDTH:0] MAXV = ACCX'((1 <<< (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] MINV = ACCX'(-(1 <<< (DATA_WIDTH-1)));
  state_t                      state_q, state_d;
  logic [RW-1:0]               rows_q, rows_d, r_q, r_d, d_q, d_d;
  logic [3:0]                  passes_q, passes_d, p_q, p_d;
  logic [4:0]                  shift_q, shift_d;
  logic                        relu_q, relu_d, err_q, err_d, ov_q, ov_d, acc_we;
  logic [WIDTH*DATA_WIDTH-1:0] bias_q, bias_d, od_q, od_d, rq;
  logic signed [ACC_WIDTH-1:0] acc_q [2**AW][WIDTH];
  logic [AW-1:0]               rp, dp;
  assign rp            = r_q[AW-1:0];
  assign dp            = d_q[AW-1:0];
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.err_drop  = err_q;
  // Rounding add is one bit wider so the half-LSB bias cannot wrap the accumulator.
  for (genvar c = 0; c < WIDTH; c++) begin : g_col
    logic [ACC_WIDTH:0]        rnd;
    logic signed [ACC_WIDTH:0] t, y, z;
    assign rnd = shift_q == 5'd0 ? '0 : ONE << (shift_q - 5'd1);
    assign t   = $signed({acc_q[dp][c][ACC_WIDTH-1], acc_q[dp][c]}) + $signed(rnd);
    assign y   = t >>> shift_q;
    assign z   = relu_q && y[ACC_WIDTH] ? '0 : y;
    assign rq[c*DATA_WIDTH +: DATA_WIDTH] = z > MAXV ? MAXV[DATA_WIDTH-1:0] :
                                            z < MINV ? MINV[DATA_WIDTH-1:0] : z[DATA_WIDTH-1:0];
  end
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    passes_d = passes_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    r_d      = r_q;
    p_d      = p_q;
    d_d      = d_q;
    ov_d     = ov_q;
    od_d     = od_q;
    acc_we   = 1'b0;
    err_d    = err_q | (bus.data_iv && state_q != ACCUM);
    bias_d   = bus.bias_iv ? bus.bias_id : bias_q;
    if (bus.load_layer_info) begin
      state_d  = ACCUM;
      rows_d   = bus.num_rows == '0 ? RW'(1) : bus.num_rows > RW'(ROWS_MAX) ? RW'(ROWS_MAX) : bus.num_rows;
      passes_d = bus.num_passes == 4'd0 ? 4'd1 : bus.num_passes;
      shift_d  = int'(bus.shift) >= ACC_WIDTH ? 5'(ACC_WIDTH-1) : bus.shift;
      relu_d   = bus.relu_en;
      r_d      = '0;
      p_d      = '0;
      d_d      = '0;
      ov_d     = 1'b0;
      err_d    = 1'b0;
    end else if (state_q == ACCUM && bus.data_iv) begin
      acc_we  = 1'b1;
      r_d     = r_q == rows_q - RW'(1) ? '0 : r_q + RW'(1);
      p_d     = r_q == rows_q - RW'(1) ? p_q + 4'd1 : p_q;
      state_d = r_q == rows_q - RW'(1) && p_q == passes_q - 4'd1 ? DRAIN : ACCUM;
      p_d     = state_d == DRAIN ? 4'd0 : p_d;
      d_d     = '0;
    end else if (state_q == DRAIN && (!ov_q || bus.out_ready)) begin
      ov_d    = d_q != rows_q;
      od_d    = d_q != rows_q ? rq : od_q;
      d_d     = d_q != rows_q ? d_q + RW'(1) : d_q;
      state_d = d_q != rows_q ? DRAIN : IDLE;
    end
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q  <= IDLE;
      rows_q   <= RW'(1);
      passes_q <= 4'd1;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      r_q      <= '0;
      p_q      <= '0;
      d_q      <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      err_q    <= 1'b0;
      bias_q   <= '0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      passes_q <= passes_d;
      shift_q  <= shift_d;
      relu_q   <= relu_d;
      r_q      <= r_d;
      p_q      <= p_d;
      d_q      <= d_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      err_q    <= err_d;
      bias_q   <= bias_d;
    end
  // Row buffer has no reset; pass 0 seeds each entry with the bias.
  always_ff @(posedge clk)
    if (acc_we)
      for (int j = 0; j < WIDTH; j++)
        acc_q[rp][j] <= (p_q == 4'd0 ? ACC_WIDTH'($signed(bias_q[j*DATA_WIDTH +: DATA_WIDTH])) : acc_q[rp][j])
                        + ACC_WIDTH'($signed(bus.data_id[j*PSUM_WIDTH +: PSUM_WIDTH]));
endmodule

// File: doc/psum_accum_requant.md
# psum_accum_requant

Parametrised post-processing stage between `scalable_SA` and the layer output buffer. It replaces the fixed 8x8 accumulator and ReLU pair. The block accumulates multi-pass partial-sum rows from the array into an on-chip row buffer, then adds a per-column bias, applies optional ReLU, and performs a rounding arithmetic right shift with saturation. Results drain as DATA_WIDTH vectors over a valid/ready output port that tolerates backpressure.

## Interface
- `WIDTH`, 8: columns per row (array width).
- `HEIGHT`, 8: array height; sets PSUM growth.
- `DATA_WIDTH`, 8: signed operand/output width.
- `PSUM_WIDTH`, 2*DATA_WIDTH+$clog2(HEIGHT): signed input partial-sum width.
- `ACC_WIDTH`, PSUM_WIDTH+4: signed accumulator width (≥15 passes plus bias).
- `ROWS_MAX`, 16: row-buffer depth.
- `RW`, $clog2(ROWS_MAX+1): width of the row-count field.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `nrst` in 1: async active-low reset.
- `load_layer_info` in 1: latch the config fields and start a new tile.
- `num_rows` in RW: rows per tile, 1..ROWS_MAX.
- `num_passes` in 4: partial-sum passes per row, 1..15.
- `shift` in 5: requant right-shift amount.
- `relu_en` in 1: ReLU enable.
- `bias_iv` in 1: bias load strobe.
- `bias_id` in WIDTH*DATA_WIDTH: signed bias, one per column.
- `data_iv` in 1: partial-sum row valid. There is no ready; the array cannot stall.
- `data_id` in WIDTH*PSUM_WIDTH: signed partial-sum row.
- `out_valid` out 1: output row valid.
- `out_ready` in 1: consumer accepts the row.
- `out_data` out WIDTH*DATA_WIDTH: signed requantised row.
- `busy` out 1: state is not IDLE.
- `err_drop` out 1: sticky; a `data_iv` beat arrived outside ACCUM.

## Operation
- **FSM states:** IDLE, ACCUM, DRAIN.
- **Config latch:** `load_layer_info` in any state latches `num_rows`, `num_passes`, `shift` and `relu_en`, clears the row and pass counters, clears `err_drop`, drops `out_valid`, and enters ACCUM. Mid-tile, this aborts the tile.
- **Config clamps:**
  - `num_rows`=0 is treated as 1; values above ROWS_MAX are treated as ROWS_MAX.
  - `num_passes`=0 is treated as 1.
  - `shift` ≥ ACC_WIDTH is clamped to ACC_WIDTH-1.
- **Bias:** `bias_iv` loads the bias register in any state. The bias is sign-extended to ACC_WIDTH.
- **ACCUM, per `data_iv` beat at row r, pass p:**
  - p==0: acc[r][j] = sext(data_id[j]) + bias[j].
  - p>0: acc[r][j] += sext(data_id[j]).
  - Addition wraps modulo 2^ACC_WIDTH.
- **Counters:** r increments per beat. At r==num_rows-1, r wraps to 0 and p increments. The beat with p==num_passes-1 and r==num_rows-1 moves the FSM to DRAIN.
- **Dropped beats:** `data_iv` in IDLE or DRAIN is ignored and sets `err_drop`.
- **DRAIN:** the read row pointer d steps 0..num_rows-1. The output register loads requant(acc[d]) when `!out_valid || out_ready`.
- **Exit:** after the last row handshakes, the FSM returns to IDLE and `out_valid` falls.
- **Requant, per column:**
  - t = acc + (shift ? 1<<(shift-1) : 0), then y = t >>> shift (round half-up).
  - If `relu_en` and y<0, then y=0.
  - Saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- **Pass-through case:** with `num_passes`=1 and `shift`=0, the block is an exact bias-add/ReLU/saturate unit.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0, `busy`=0, `err_drop`=0, state IDLE, counters 0, bias 0. Buffer contents are don't-care.
- **Accumulate:** a beat at cycle t updates acc at the edge ending t.
- **DRAIN entry:** the last beat at t puts DRAIN in state at t+1; the first `out_valid` is seen at t+2.
- **Throughput:** with `out_ready` held high, rows emit one per cycle, in order 0..num_rows-1.
- **Backpressure:** while `out_valid && !out_ready`, `out_data` is held stable. No row is lost or duplicated.
- **Simultaneous events:**
  - `load_layer_info` and `data_iv` in the same cycle: the beat is dropped without setting `err_drop`; the counters start from 0.
  - `bias_iv` and the first beat of pass 0 in the same cycle: the beat uses the old bias.
- **Async reset:** `nrst` low mid-tile immediately forces all outputs to their reset values.

## Test plan
- **Reset:** assert `nrst`=0 mid-DRAIN → `out_valid`, `out_data`, `busy` and `err_drop` all read 0 within the same cycle.
- **Single pass:** WIDTH=8, `num_rows`=2, `shift`=0, ReLU off, bias[j]=j-3; row0 all 5, row1 all -10 → out row0[j]=j+2, row1[j]=j-13; `out_valid` first high 2 cycles after the last beat.
- **Multi-pass rounding:** `num_passes`=3, `num_rows`=1, bias 0, `shift`=2; data 101 on each pass → acc 303, out (303+2)>>>2 = 76 in every column.
- **Saturation and ReLU:** acc {1000, -50, -1000} with `shift`=0 → ReLU off gives {127, -50, -128}; ReLU on gives {127, 0, 0}.
- **Backpressure:** `num_rows`=4, `out_ready` low for 3 cycles after the first valid, then toggling 1/0 → rows 0..3 arrive once each, in order; `out_data` stays stable while stalled.
- **Drop and abort:** `data_iv` in IDLE → `err_drop`=1 and no output. Then `load_layer_info` during DRAIN → `out_valid`=0 next cycle, `err_drop` clears, and a fresh tile completes correctly.
